// File: rtl/keypad_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_pkg - scan state type, column reset pattern and key-map helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } scan_state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  function automatic logic [3:0] key_encode(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest-indexed active-low row wins when several rows are pulled low.
  function automatic logic [1:0] first_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_2ff - two-flop synchronizer, resets to all-ones (idle pulled-up rows)
// Revision: 1.0
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_scan_ctrl - 4x4 keypad column scanner with press/release debounce
// Revision: 1.0
// ---------------------------------------------------------------------------
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    rows_s;
  scan_state_t   state_q, state_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          row_low;
  logic          valid_now;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rows),
    .q_o   (rows_s)
  );

  assign row_low = ~rows_s[row_idx_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SCAN;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      row_idx_q  <= 2'd0;
      col_idx_q  <= 2'd0;
      key_code_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      row_idx_q  <= row_idx_d;
      col_idx_q  <= col_idx_d;
      key_code_q <= key_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    row_idx_d  = row_idx_q;
    col_idx_d  = col_idx_q;
    key_code_d = key_code_q;
    valid_now  = 1'b0;
    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (rows_s != 4'hF) begin
            row_idx_d = first_low_row(rows_s);
            db_cnt_d  = '0;
            state_d   = DB_PRESS;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      DB_PRESS: begin
        if (db_cnt_q == DB_LAST) begin
          db_cnt_d = '0;
          if (row_low) begin
            valid_now  = 1'b1;
            key_code_d = key_encode(row_idx_q, col_idx_q);
            state_d    = PRESSED;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!row_low) begin
          db_cnt_d = '0;
          state_d  = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (db_cnt_q == DB_LAST) begin
          db_cnt_d = '0;
          if (!row_low) begin
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end else begin
            state_d = PRESSED;
          end
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = SCAN;
        scan_cnt_d = '0;
        db_cnt_d   = '0;
        row_idx_d  = 2'd0;
        col_idx_d  = 2'd0;
        key_code_d = 4'h0;
      end
    endcase
  end

  // The strobe fires in the confirming cycle, so the fresh code is forwarded
  // alongside it instead of appearing one cycle late.
  assign key_valid = valid_now;
  assign key_code  = valid_now ? key_code_d : key_code_q;
  assign key_held  = (state_q == PRESSED) || (state_q == DB_RELEASE);
  assign cols      = ~((~COL_RESET) << col_idx_q);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl - bench for keypad_scan_ctrl against a timeline model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

  localparam int SCAN_N = 4;
  localparam int DB_N   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows = 4'hF;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_CYCLES(SCAN_N), .DEBOUNCE_CYCLES(DB_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Timeline model: decisions are scheduled at absolute cycle numbers.
  int         cyc;
  int         m_col;
  int         m_row;
  int         m_due;
  bit         m_confirming;
  bit         m_held;
  bit         m_releasing;
  logic [3:0] m_code;
  logic [3:0] m_meta;
  logic [3:0] m_rs;

  function automatic logic [3:0] key_val(input int r, input int c);
    string keys;
    byte   ch;
    keys = "123A456B789CE0FD";
    ch = keys[r*4 + c];
    if (ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  function automatic int lowest_low(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] exp_cols();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << m_col);
  endfunction

  function automatic bit exp_valid();
    return m_confirming && (cyc == m_due) && !m_rs[m_row];
  endfunction

  function automatic logic [3:0] exp_code();
    return exp_valid() ? key_val(m_row, m_col) : m_code;
  endfunction

  task automatic model_reset();
    cyc = 0; m_col = 0; m_row = 0; m_due = SCAN_N - 1;
    m_confirming = 0; m_held = 0; m_releasing = 0;
    m_code = 4'h0; m_meta = 4'hF; m_rs = 4'hF;
  endtask

  task automatic model_step(input logic [3:0] r);
    if (m_confirming) begin
      if (cyc == m_due) begin
        m_confirming = 0;
        if (!m_rs[m_row]) begin
          m_held = 1;
          m_code = key_val(m_row, m_col);
        end else begin
          m_col = (m_col + 1) % 4;
          m_due = cyc + SCAN_N;
        end
      end
    end else if (m_held) begin
      if (m_rs[m_row]) begin
        m_held = 0; m_releasing = 1; m_due = cyc + DB_N;
      end
    end else if (m_releasing) begin
      if (cyc == m_due) begin
        m_releasing = 0;
        if (m_rs[m_row]) begin
          m_col = (m_col + 1) % 4;
          m_due = cyc + SCAN_N;
        end else begin
          m_held = 1;
        end
      end
    end else if (cyc == m_due) begin
      if (m_rs != 4'hF) begin
        m_row = lowest_low(m_rs);
        m_confirming = 1;
        m_due = cyc + DB_N;
      end else begin
        m_col = (m_col + 1) % 4;
        m_due = cyc + SCAN_N;
      end
    end
    m_rs = m_meta;
    m_meta = r;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Called at a falling edge: compare, apply this cycle's rows, advance model.
  task automatic cycle(input logic [3:0] r);
    check("outputs{cols,valid,held,code}", {22'd0, cols, key_valid, key_held, key_code},
          {22'd0, exp_cols(), exp_valid(), (m_held || m_releasing), exp_code()});
    if (key_valid === 1'b1) n_valid++;
    rows = r;
    model_step(r);
    @(negedge clk);
  endtask

  // Physical keypad: pressed rows read low only while their column is driven.
  task automatic press(input logic [3:0] mask, input int c);
    logic [3:0] ec;
    ec = exp_cols();
    cycle(ec[c] ? 4'hF : ~mask);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    rows = 4'hF;
    #1;
    check("reset_cols", {28'd0, cols}, 32'hE);
    check("reset_code", {28'd0, key_code}, 32'h0);
    check("reset_valid_held", {30'd0, key_valid, key_held}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_valid = 0;
  endtask

  typedef struct {
    logic [3:0] mask;
    int         col;
    int         hold;
    logic [3:0] exp_code;
    int         exp_valid;
  } vec_t;

  vec_t vt[8];

  task automatic random_phase();
    int rr, cc, hold, gap;
    logic [3:0] mask;
    for (int it = 0; it < 25; it++) begin
      rr = $urandom_range(0, 3);
      cc = $urandom_range(0, 3);
      hold = $urandom_range(0, 90);
      gap = $urandom_range(25, 60);
      mask = 4'b0001 << rr;
      if ($urandom_range(0, 3) == 0) mask = mask | (4'b0001 << $urandom_range(0, 3));
      for (int k = 0; k < hold; k++) begin
        if (k < 6 && $urandom_range(0, 1) == 0) cycle(4'hF);
        else press(mask, cc);
      end
      for (int k = 0; k < gap; k++) cycle(4'hF);
    end
  endtask

  initial begin
    int fin;
    vt[0] = '{4'b0000, 0, 40,  4'h0, 0};
    vt[1] = '{4'b0010, 2, 100, 4'h6, 1};
    vt[2] = '{4'b0101, 1, 100, 4'h2, 1};
    vt[3] = '{4'b1000, 3, 100, 4'hD, 1};
    vt[4] = '{4'b0001, 0, 8,   4'hD, 0};
    vt[5] = '{4'b0100, 1, 100, 4'h8, 1};
    vt[6] = '{4'b1000, 1, 100, 4'h0, 1};
    vt[7] = '{4'b0001, 3, 100, 4'hA, 1};

    @(negedge clk);
    apply_reset();

    for (int i = 0; i < 8; i++) begin
      n_valid = 0;
      for (int k = 0; k < vt[i].hold; k++) press(vt[i].mask, vt[i].col);
      for (int k = 0; k < 60; k++) cycle(4'hF);
      check($sformatf("vec%0d_valid_count", i), n_valid, vt[i].exp_valid);
      check($sformatf("vec%0d_code", i), {28'd0, key_code}, {28'd0, vt[i].exp_code});
      check($sformatf("vec%0d_held", i), {31'd0, key_held}, 32'd0);
    end

    // Press bounce ending high at the final debounce count.
    apply_reset();
    fin = -1;
    for (int k = 0; k < 200; k++) begin
      if (m_confirming && fin < 0) fin = m_due;
      if (fin >= 0 && cyc > fin) break;
      if (fin < 0) cycle(4'b1110);
      else if (cyc >= fin - 3) cycle(4'hF);
      else cycle(((cyc / 3) % 2) ? 4'hF : 4'b1110);
    end
    check("bounce_cols_next", {28'd0, cols}, 32'hD);
    check("bounce_no_valid", n_valid, 0);
    for (int k = 0; k < 20; k++) cycle(4'hF);

    // Release bounce on key D, then a clean release.
    n_valid = 0;
    for (int k = 0; k < 200 && !m_held; k++) press(4'b1000, 3);
    for (int k = 0; k < 3; k++) press(4'b1000, 3);
    for (int k = 0; k < 5; k++) cycle(4'hF);
    for (int k = 0; k < 40; k++) press(4'b1000, 3);
    check("relbounce_valid_count", n_valid, 1);
    check("relbounce_held", {31'd0, key_held}, 32'd1);
    check("relbounce_code", {28'd0, key_code}, 32'hD);
    for (int k = 0; k < 100 && (m_held || m_releasing); k++) cycle(4'hF);
    check("release_cols", {28'd0, cols}, 32'hE);
    check("release_held", {31'd0, key_held}, 32'd0);
    check("release_valid_count", n_valid, 1);

    // Asynchronous reset at debounce count 10.
    for (int k = 0; k < 200 && !(m_confirming && cyc == m_due - DB_N + 11); k++)
      press(4'b0100, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_cols", {28'd0, cols}, 32'hE);
    check("async_held_valid", {30'd0, key_held, key_valid}, 32'd0);
    check("async_code", {28'd0, key_code}, 32'h0);
    rows = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_valid = 0;
    for (int k = 0; k < 40; k++) cycle(4'hF);
    check("async_no_spurious_valid", n_valid, 0);

    random_phase();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences a 4x4 matrix keypad: drives one active-low column at a time, samples the rows through a synchronizer, debounces press and release, and encodes the key.
- Emits a one-cycle `key_valid` strobe per confirmed press, with a stable 4-bit hex `key_code`.
- Sits between the keypad pins and the hex-digit/display logic. It owns column drive and the debounce timing.

Parameters:
- SCAN_CYCLES, 4: clock cycles each column stays driven before rotation; minimum 3, to cover synchronizer latency.
- DEBOUNCE_CYCLES, 20: clock cycles in each debounce window. Simulation value; hardware build uses 960000 (20 ms at 48 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rows  in  4  keypad row inputs; active-low, externally pulled up; asynchronous to clk
- cols  out  4  column drive; active-low, exactly one bit low at all times
- key_code  out  4  hex code of the last confirmed key
- key_valid  out  1  one-cycle pulse when a press is confirmed
- key_held  out  1  high while a confirmed key is still pressed, including during release debounce

Behaviour:
- Reset values (asynchronous, immediate):
  - cols = 4'b1110; key_code = 4'h0; key_valid = 0; key_held = 0.
  - state = SCAN; scan and debounce counters = 0; latched row/column index = 0.
- Synchronizer: rows pass through a 2-flop synchronizer, giving rows_s with 2 cycles of latency. All decisions use rows_s only.
- Counter widths: scan counter is $clog2(SCAN_CYCLES) bits; debounce counter is $clog2(DEBOUNCE_CYCLES) bits. Both compare against parameter-1 and never wrap past it.
- State SCAN:
  - The scan counter increments each cycle; rows_s is evaluated only on the final dwell cycle (cnt == SCAN_CYCLES-1).
  - If any rows_s bit is 0: latch the lowest-indexed low row and the current column index, then go to DB_PRESS. cols is held.
  - Otherwise: rotate cols left (1110 -> 1101 -> 1011 -> 0111 -> 1110) and clear the counter.
- State DB_PRESS:
  - The debounce counter increments. Glitches before the final cycle are ignored.
  - On cnt == DEBOUNCE_CYCLES-1, if the latched row is still 0 in rows_s: go to PRESSED, load key_code, pulse key_valid for exactly this one cycle.
  - On cnt == DEBOUNCE_CYCLES-1, if the latched row is no longer 0: go to SCAN. Rotate cols to the next column; key_valid stays 0.
- State PRESSED:
  - key_held = 1; cols and key_code are held.
  - When the latched row goes 1: go to DB_RELEASE.
  - Other rows and columns are ignored: no rollover, no second key.
- State DB_RELEASE:
  - key_held stays 1; the debounce counter increments.
  - On final count, if the latched row is 1: go to SCAN, key_held = 0, rotate cols to the next column.
  - On final count, if the latched row is 0: return to PRESSED with no new key_valid.
- Key encoding, row r / column c, rows 0..3 by columns 0..3:
  - row 0 = 1,2,3,A
  - row 1 = 4,5,6,B
  - row 2 = 7,8,9,C
  - row 3 = E,0,F,D
- key_code persists after release until the next confirmed press.
- Simultaneous low rows at detection: lowest index wins.
- Counter clearing: the debounce counter clears on every state entry. The scan counter clears on leaving SCAN.
- Reset asserted mid-debounce or while PRESSED: all outputs return to reset values immediately. No key_valid is emitted on deassertion.
- Latency: from rows_s showing a key on the final dwell cycle, key_valid rises DEBOUNCE_CYCLES cycles later.
- Illegal or unused state encodings: recover to SCAN with reset output values.

Decomposition:
- Package keypad_pkg holds:
  - typedef enum logic [1:0] {SCAN, DB_PRESS, PRESSED, DB_RELEASE} scan_state_t
  - COL_RESET = 4'b1110
  - a function key_encode(row_idx, col_idx) returning logic [3:0]
- One sub-module, sync_2ff: a parameterized-width 2-flop synchronizer with async active-high reset to all-ones (idle rows).

Test Plan:
- Idle scan: rows = 4'hF for 40 cycles -> cols steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_valid and key_held never assert.
- Clean press: hold row1 low only while cols = 1011 (column 2), for 100 cycles -> one key_valid pulse; key_code = 4'h6; key_held = 1 until release debounce completes; cols frozen at 1011 throughout.
- Bounce: toggle row0 low/high every 3 cycles during DB_PRESS, end high at the final count -> no key_valid; scan resumes at the next column.
- Release bounce: after confirming key 4'hD (row3, col3), make row3 high for 5 cycles, then low -> returns to PRESSED, no second key_valid; then a clean release -> key_held = 0, cols = 1110.
- Two rows: rows = 4'b0101 on column 1 -> key_code = 4'h2 (row0 wins).
- Async reset: assert reset at debounce count 10 with no clock edge -> cols = 1110 and key_held = 0 at once; after deassertion, no spurious key_valid.
